// File: rtl/alu_iter_if.sv
// alu_iter_if: start/done request bus between the register file, the iterative ALU and writeback.
`default_nettype none

interface alu_iter_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       Op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             addOF;
  logic             zero;
  logic             slt;

  modport master (
    output start, a, b, Op,
    input  busy, done, result, hi, addOF, zero, slt
  );

  modport slave (
    input  start, a, b, Op,
    output busy, done, result, hi, addOF, zero, slt
  );
endinterface

`default_nettype wire

// File: rtl/alu_iter.sv
// ---------------------------------------------------------------------------
// Module   : alu_iter
// Purpose  : Registered ALU with start/done handshake. Logic and arithmetic
//            ops take one cycle, shifts/rotates step one bit per cycle, and
//            MULU is a WIDTH-step shift-add multiplier.
//            Define ALU_SAT_EN to make ADD/SUB saturate on signed overflow.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_iter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic     clk,
  input  logic     rst,
  alu_iter_if.slave bus
);

  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [3:0] OP_NOT  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_MULU = 4'd11;
  localparam logic [3:0] OP_SLT  = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [3:0]           cur_op;
  logic [WIDTH-1:0]     work;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   prod;
  logic [CNT_W-1:0]     count;
  logic [WIDTH-1:0]     res_q;
  logic [WIDTH-1:0]     hi_q;
  logic                 addof_q;
  logic                 zero_q;
  logic                 slt_q;

  logic [SHAMT_W-1:0]   shamt;
  logic                 is_shift;
  logic                 is_mul;
  logic                 accept;
  logic                 go_run;
  logic                 last_step;

  assign shamt     = bus.b[SHAMT_W-1:0];
  assign is_shift  = (bus.Op >= OP_SLL) && (bus.Op <= OP_ROL);
  assign is_mul    = (bus.Op == OP_MULU);
  assign accept    = bus.start && (state != S_RUN);
  assign go_run    = is_mul || (is_shift && (shamt != '0));
  assign last_step = (count == CNT_W'(1));

  // Single-cycle result path, evaluated straight from the live operands.
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic             lt;
  logic [WIDTH-1:0] os_res;
  logic             os_of;
  logic             os_slt;
  logic             os_zero;

  always_comb begin
    b_eff   = (bus.Op == OP_ADD) ? bus.b : ~bus.b;
    sum     = bus.a + b_eff + WIDTH'(bus.Op != OP_ADD);
    ovf     = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    lt      = sum[WIDTH-1] ^ ovf;
    os_res  = '0;
    os_of   = 1'b0;
    os_slt  = 1'b0;
    case (bus.Op)
      OP_NOT: os_res = ~bus.a;
      OP_AND: os_res = bus.a & bus.b;
      OP_OR:  os_res = bus.a | bus.b;
      OP_XOR: os_res = bus.a ^ bus.b;
      OP_ADD, OP_SUB: begin
        os_res = sum;
        os_of  = ovf;
        os_slt = (bus.Op == OP_SUB) ? lt : 1'b0;
`ifdef ALU_SAT_EN
        // Operands share a sign on overflow, so a's sign tells the direction.
        if (ovf) begin
          os_res = bus.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end
      OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL: os_res = bus.a;
      OP_SLT: begin
        os_res = WIDTH'(lt);
        os_slt = lt;
      end
      default: os_res = '0;
    endcase
    // Reserved opcodes report every flag low, including zero.
    os_zero = (bus.Op <= OP_SLT) && (os_res == '0);
  end

  logic [WIDTH-1:0]   shift_next;
  logic [WIDTH:0]     mul_add;
  logic [2*WIDTH-1:0] prod_next;

  always_comb begin
    shift_next = work;
    case (cur_op)
      OP_SLL:  shift_next = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, work[WIDTH-1:1]};
      OP_SRA:  shift_next = {work[WIDTH-1], work[WIDTH-1:1]};
      OP_ROR:  shift_next = {work[0], work[WIDTH-1:1]};
      OP_ROL:  shift_next = {work[WIDTH-2:0], work[WIDTH-1]};
      default: shift_next = work;
    endcase
    mul_add   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_next = {mul_add, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_next = go_run ? S_RUN : S_DONE;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RUN:   state_next = last_step ? S_DONE : S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_op  <= '0;
      work    <= '0;
      mcand   <= '0;
      prod    <= '0;
      count   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      addof_q <= 1'b0;
      zero_q  <= 1'b0;
      slt_q   <= 1'b0;
    end else if (accept) begin
      cur_op <= bus.Op;
      if (is_mul) begin
        mcand <= bus.a;
        prod  <= {{WIDTH{1'b0}}, bus.b};
        count <= CNT_W'(WIDTH);
      end else if (go_run) begin
        work  <= bus.a;
        count <= {1'b0, shamt};
      end else begin
        res_q   <= os_res;
        hi_q    <= '0;
        addof_q <= os_of;
        zero_q  <= os_zero;
        slt_q   <= os_slt;
      end
    end else if (state == S_RUN) begin
      count <= count - CNT_W'(1);
      if (cur_op == OP_MULU) begin
        prod <= prod_next;
        if (last_step) begin
          res_q   <= prod_next[WIDTH-1:0];
          hi_q    <= prod_next[2*WIDTH-1:WIDTH];
          addof_q <= 1'b0;
          zero_q  <= (prod_next == '0);
          slt_q   <= 1'b0;
        end
      end else begin
        work <= shift_next;
        if (last_step) begin
          res_q   <= shift_next;
          hi_q    <= '0;
          addof_q <= 1'b0;
          zero_q  <= (shift_next == '0);
          slt_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.busy   = (state == S_RUN);
  assign bus.done   = (state == S_DONE);
  assign bus.result = res_q;
  assign bus.hi     = hi_q;
  assign bus.addOF  = addof_q;
  assign bus.zero   = zero_q;
  assign bus.slt    = slt_q;

endmodule

`default_nettype wire

// File: doc/alu_iter.md
Name: alu_iter

Overview:
Parametrised, registered successor to the combinational 8-bit ALU, with start/done handshake and captured operands. Single-cycle logic and arithmetic ops complete in 1 cycle. Variable-amount shifts/rotates iterate 1 bit per cycle. Unsigned multiply is iterative shift-add producing a double-width product. Sits between the datapath register file and writeback.

Parameters:
WIDTH, 8, operand/result width (>=4)
SHAMT_W, 3, shift-amount width; must equal clog2(WIDTH)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  request; accepted only when busy=0
a  in  WIDTH  operand A, captured on accepted start
b  in  WIDTH  operand B / shift amount (b[SHAMT_W-1:0]), captured on accepted start
Op  in  4  opcode, captured on accepted start
busy  out  1  high while iterating (state RUN)
done  out  1  high for each cycle the state is DONE; result/flags valid
result  out  WIDTH  result (low half of product for MULU)
hi  out  WIDTH  high half of product for MULU; 0 for all other ops
addOF  out  1  signed overflow for ADD/SUB; 0 otherwise
zero  out  1  result==0 (and hi==0 for MULU)
slt  out  1  signed a<b for SUB and SLT; 0 otherwise

Behaviour:
- Clock is clk; reset is rst: asynchronous, active-high. On reset: state IDLE; busy, done, result, hi, addOF, zero, slt = 0; internal counters and working regs = 0.
- States: IDLE, RUN, DONE. start is accepted in IDLE or DONE; ignored in RUN. In RUN, changes on a/b/Op have no effect.
- Opcodes:
  - 0 NOT a
  - 1 AND
  - 2 OR
  - 3 XOR
  - 4 ADD
  - 5 SUB
  - 6 SLL
  - 7 SRL
  - 8 SRA
  - 9 ROR
  - 10 ROL
  - 11 MULU
  - 12 SLT (result = {0..0, slt})
  - 13-15: result 0, all flags 0, latency 1
- Single-cycle ops (0-5, 12-15): on the accept edge, outputs load and state goes to DONE. done is high the next cycle (latency 1). Back-to-back accepts in DONE give one result per cycle, with done held high.
- Shifts/rotates (6-10), k = b[SHAMT_W-1:0]:
  - k=0: behave as a single-cycle op, result = a.
  - k>0: the accept edge loads the working reg and count=k, and enters RUN. Each RUN edge shifts 1 bit and decrements count. The edge where count reaches 0 loads result and enters DONE. done is first high k+1 cycles after the accept cycle.
  - SRA replicates the MSB. Rotates wrap the bit shifted out.
- MULU:
  - Unsigned shift-add, exactly WIDTH RUN iterations. {hi,result} = a*b, exact with no truncation.
  - done is first high WIDTH+1 cycles after the accept cycle.
- Arithmetic:
  - SUB = a + ~b + 1.
  - addOF = (a_msb==b'_msb) && (sum_msb!=a_msb), where b' is b for ADD and ~b for SUB.
  - slt = sum_msb XOR addOF, i.e. true signed comparison valid under overflow.
- Flags update only on the edge entering DONE. They hold their last values through IDLE/RUN until the next completion. result/hi likewise hold.
- DONE with no start goes to IDLE next edge; done drops.
- Reset mid-RUN aborts the op: no done pulse, outputs 0.
- start coincident with rst is lost.

Optional Feature:
ALU_SAT_EN:
- When defined, ADD/SUB saturate on overflow: positive overflow gives 0 followed by all 1s (max signed); negative overflow gives 1 followed by all 0s (min signed). addOF still reports 1, and zero is computed on the clamped result.
- When undefined, ADD/SUB wrap modulo 2^WIDTH. No other op is affected in either case.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 -> done 1 cycle later, result=0x80, addOF=1, zero=0. With ALU_SAT_EN: result=0x7F, addOF=1.
- SUB a=0x03 b=0x05 -> result=0xFE, slt=1, addOF=0. SUB a=0x80 b=0x01 -> result=0x7F, addOF=1, slt=1.
- SRA a=0x90 b=3 -> busy for 3 cycles, done on cycle 4, result=0xF2. SLL a=0xA5 b=0 -> done after 1 cycle, result=0xA5. ROL a=0x81 b=1 -> result=0x03.
- MULU a=0xFF b=0xFF -> done 9 cycles after start, hi=0xFE, result=0x01, zero=0. MULU a=0x00 b=0x37 -> hi=0, result=0, zero=1.
- During a MULU run, pulse start with Op=4 and change a/b -> ignored; MULU result is unaffected; busy stays high until the run completes.
- Assert rst on cycle 4 of a MULU -> all outputs 0 immediately, state IDLE, no done. ADD 0x02+0x03 issued right after reset release -> result=0x05 after 1 cycle.
